// File: rtl/stepper_ctrl.sv
// ============================================================================
//  Module   : stepper_ctrl
//  Purpose  : Wave / full-step / half-step sequencer for a 4-coil unipolar
//             stepper, with step-count moves, abort, hold torque and position.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stepper_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic             stop,
    input  logic             hold_en,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam logic [1:0] MODE_FULL = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [DIV_W-1:0] per_q,   per_d;
    logic             dir_q,   dir_d;
    logic             half_q,  half_d;
    logic [3:0]       coil_q,  coil_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             tick;
    logic [2:0]       phase_delta;
    logic [POS_W-1:0] pos_delta;

    function automatic logic [3:0] phase_coil(input logic [2:0] ph);
        logic [3:0] pat;
        case (ph)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign tick        = (div_q == (per_q - 1'b1));
    assign phase_delta = half_q ? 3'd1 : 3'd2;
    assign pos_delta   = half_q ? POS_W'(1) : POS_W'(2);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        div_d   = div_q;
        per_d   = per_q;
        dir_d   = dir_q;
        half_d  = half_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        half_d  = (mode == MODE_HALF);
                        per_d   = (period == '0) ? DIV_W'(1) : period;
                        div_d   = '0;
                        state_d = RUN;
                        // Snap onto the index parity the selected mode uses.
                        case (mode)
                            MODE_FULL: phase_d = {phase_q[2:1], 1'b1};
                            MODE_HALF: phase_d = phase_q;
                            default:   phase_d = {phase_q[2:1], 1'b0};
                        endcase
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident tick: no step is taken.
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    div_d   = '0;
                    phase_d = dir_q ? (phase_q - phase_delta) : (phase_q + phase_delta);
                    pos_d   = dir_q ? (pos_q - pos_delta) : (pos_q + pos_delta);
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        coil_d = (busy_d || hold_en) ? phase_coil(phase_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            pos_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            per_q   <= DIV_W'(1);
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            coil_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            coil_q  <= coil_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign coil     = coil_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_ctrl.sv
// ============================================================================
//  Module   : tb_stepper_ctrl
//  Purpose  : Directed, table-driven checks of stepper_ctrl (POS_W = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stepper_ctrl;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
    localparam int POS_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             dir;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic             stop;
    logic             hold_en;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    int n_cmp = 0;
    int n_bad = 0;

    stepper_ctrl #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W),
        .POS_W (POS_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .steps    (steps),
        .dir      (dir),
        .mode     (mode),
        .period   (period),
        .stop     (stop),
        .hold_en  (hold_en),
        .coil     (coil),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        dir;
        logic [15:0] steps;
        logic [15:0] period;
        logic        hold;
        logic [3:0]  align_coil;
        logic [3:0]  end_coil;
        logic [3:0]  end_pos;
        int          cycles;
    } vec_t;

    vec_t tbl[7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic d, input logic [15:0] n,
                         input logic [15:0] p);
        mode   = m;
        dir    = d;
        steps  = n;
        period = p;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    initial begin
        // Phase/position carry over from the half-step sequence that precedes the table.
        tbl[0] = '{2'd2, 1'b1, 16'd2, 16'd1, 1'b1, 4'b0110, 4'b1100, 4'h1, 2};
        tbl[1] = '{2'd0, 1'b1, 16'd2, 16'd0, 1'b1, 4'b1000, 4'b0010, 4'hD, 2};
        tbl[2] = '{2'd1, 1'b0, 16'd0, 16'd1, 1'b1, 4'b0010, 4'b0010, 4'hD, 0};
        tbl[3] = '{2'd1, 1'b0, 16'd4, 16'd1, 1'b1, 4'b0011, 4'b0011, 4'h5, 4};
        tbl[4] = '{2'd3, 1'b0, 16'd1, 16'd3, 1'b1, 4'b0010, 4'b0001, 4'h7, 3};
        tbl[5] = '{2'd2, 1'b0, 16'd3, 16'd1, 1'b1, 4'b0001, 4'b1100, 4'hA, 3};
        tbl[6] = '{2'd0, 1'b0, 16'd1, 16'd2, 1'b0, 4'b1000, 4'b0000, 4'hC, 2};

        rst_n = 1'b0; start = 1'b0; steps = '0; dir = 1'b0; mode = 2'd0;
        period = '0; stop = 1'b0; hold_en = 1'b0;
        cyc();
        cyc();
        chk("reset_coil", coil, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_pos", position, 4'h0);
        rst_n   = 1'b1;
        hold_en = 1'b1;
        cyc();

        // Half-step CW, 3 steps at period 2 from phase 0.
        issue(2'd2, 1'b0, 16'd3, 16'd2);
        chk("hs_k_busy", busy, 1'b1);
        chk("hs_k_coil", coil, 4'b1000);
        cyc();
        chk("hs_k1_coil", coil, 4'b1000);
        cyc();
        chk("hs_k2_coil", coil, 4'b1100);
        chk("hs_k2_pos", position, 4'h1);
        cyc();
        cyc();
        chk("hs_k4_coil", coil, 4'b0100);
        chk("hs_k4_pos", position, 4'h2);
        cyc();
        chk("hs_k5_done", done, 1'b0);
        cyc();
        chk("hs_k6_coil", coil, 4'b0110);
        chk("hs_k6_done", done, 1'b1);
        chk("hs_k6_busy", busy, 1'b0);
        chk("hs_k6_pos", position, 4'h3);
        cyc();
        chk("hs_k7_done", done, 1'b0);

        for (int i = 0; i < 7; i++) begin
            hold_en = tbl[i].hold;
            issue(tbl[i].mode, tbl[i].dir, tbl[i].steps, tbl[i].period);
            if (tbl[i].cycles == 0) begin
                chk($sformatf("v%0d_zero_done", i), done, 1'b1);
                chk($sformatf("v%0d_zero_busy", i), busy, 1'b0);
            end else begin
                chk($sformatf("v%0d_align_busy", i), busy, 1'b1);
                chk($sformatf("v%0d_align_coil", i), coil, tbl[i].align_coil);
                for (int c = 1; c < tbl[i].cycles; c++) begin
                    cyc();
                    chk($sformatf("v%0d_run_busy", i), busy, 1'b1);
                end
                cyc();
                chk($sformatf("v%0d_done", i), done, 1'b1);
                chk($sformatf("v%0d_busy", i), busy, 1'b0);
            end
            chk($sformatf("v%0d_coil", i), coil, tbl[i].end_coil);
            chk($sformatf("v%0d_pos", i), position, tbl[i].end_pos);
            cyc();
            chk($sformatf("v%0d_done_clr", i), done, 1'b0);
        end

        // Stop coincident with the second tick: one step, no done.
        hold_en = 1'b1;
        issue(2'd2, 1'b0, 16'd10, 16'd3);
        chk("stop_k_coil", coil, 4'b0100);
        cyc();
        cyc();
        cyc();
        chk("stop_k3_coil", coil, 4'b0110);
        chk("stop_k3_pos", position, 4'hD);
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_done", done, 1'b0);
        chk("stop_coil", coil, 4'b0110);
        chk("stop_pos", position, 4'hD);
        hold_en = 1'b0;
        cyc();
        chk("nohold_coil", coil, 4'b0000);
        chk("nohold_done", done, 1'b0);
        hold_en = 1'b1;
        cyc();
        chk("hold_coil", coil, 4'b0110);

        // A second start during RUN must not reload the command.
        issue(2'd2, 1'b0, 16'd2, 16'd2);
        chk("bs_k_coil", coil, 4'b0110);
        mode = 2'd0; dir = 1'b1; steps = 16'd5; period = 16'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("bs_k2_coil", coil, 4'b0010);
        chk("bs_k2_pos", position, 4'hE);
        cyc();
        cyc();
        chk("bs_done", done, 1'b1);
        chk("bs_busy", busy, 1'b0);
        chk("bs_coil", coil, 4'b0011);
        chk("bs_pos", position, 4'hF);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("idle_stop_coil", coil, 4'b0011);
        chk("idle_stop_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a move.
        issue(2'd2, 1'b0, 16'd10, 16'd2);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rm_pre_pos", position, 4'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rm_coil", coil, 4'b0000);
        chk("rm_busy", busy, 1'b0);
        chk("rm_done", done, 1'b0);
        chk("rm_pos", position, 4'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rm_phase0_coil", coil, 4'b1000);
        chk("rm_after_busy", busy, 1'b0);
        chk("rm_after_done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stepper_ctrl.md
# stepper_ctrl

Parametrised stepper-motor sequencer for a 4-coil unipolar motor. It runs three drive modes: wave, two-phase full-step and half-step. A move is a commanded number of steps at a programmable step period, in either direction, with busy/done status, abort, optional holding torque and a signed position counter. It sits between a motion-command register interface and the coil driver pins.

## Interface
Parameters:
- CNT_W, 16, width of the step-count command and remaining-step counter
- DIV_W, 16, width of the step-period command (clocks per step)
- POS_W, 24, width of the position counter (two's complement, half-step units)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  move request; sampled only in IDLE
- steps  input  CNT_W  number of steps to move; sampled with start
- dir  input  1  0 = CW (phase index increments), 1 = CCW (decrements); sampled with start
- mode  input  2  0 = wave, 1 = full two-phase, 2 = half-step, 3 = wave; sampled with start
- period  input  DIV_W  clocks per step; 0 is treated as 1; sampled with start
- stop  input  1  abort the current move
- hold_en  input  1  1 = keep the current phase energised while idle
- coil  output  4  coil drive pattern
- busy  output  1  high while a move is in progress
- done  output  1  one-cycle pulse when a move completes normally
- position  output  POS_W  signed accumulated position in half-steps

## Operation
- **Phase table.** The 3-bit phase index selects the coil pattern:
  - 0: 1000
  - 1: 1100
  - 2: 0100
  - 3: 0110
  - 4: 0010
  - 5: 0011
  - 6: 0001
  - 7: 1001
- **Mode and step delta.**
  - Wave uses only even indices.
  - Full uses only odd indices.
  - Half-step uses all eight indices.
  - Phase delta per step: ±1 in half-step mode, ±2 otherwise. The index wraps modulo 8 (7+1→0, 0−1→7, 6+2→0, 1−2→7).
- **Position delta.** Position changes by ±1 per half-step and ±2 per wave/full step. The sign follows dir (CW positive). Position wraps modulo 2^POS_W.
- **FSM states:** IDLE, RUN.
- **IDLE with start=1 and steps≠0:**
  - Latch steps, dir, mode and max(period,1).
  - Align the phase: wave/mode 3 clears bit 0, full sets bit 0, half-step leaves it unchanged. Alignment is not a step and does not change position.
  - Clear the divider, go to RUN, set busy.
- **IDLE with start=1 and steps=0:** pulse done for one cycle. No motion, busy stays 0, phase and position unchanged.
- **RUN:**
  - The divider counts clocks. When it reaches the latched period−1 (a tick), it resets and one step executes: phase and position update, and remaining decrements.
  - The tick that takes remaining to 0 also returns the FSM to IDLE, clears busy and pulses done, all on the same edge.
- **Stop in RUN:** go to IDLE on the next edge, with no step and no done. Stop beats a coincident tick. Stop in IDLE is ignored.
- **start while busy:** ignored. Command inputs are not re-sampled during RUN.
- **coil output:**
  - In RUN, coil = table[phase].
  - In IDLE, coil = hold_en ? table[phase] : 0000. hold_en takes effect combinationally into the coil register on the next edge.
- **Reset (rst_n low, asynchronous):**
  - Phase = 0, position = 0, remaining = 0, divider = 0, FSM = IDLE.
  - Outputs: coil = 0000, busy = 0, done = 0.
  - Reset mid-move abandons the move with no done pulse.

## Timing
- All outputs are registered.
- With start accepted at edge k, P = max(period,1) and N = steps:
  - busy is high from edge k.
  - Aligned phase is visible on coil from edge k.
  - Step i (1..N) appears on coil and position at edge k+i·P.
  - done is high and busy is low after edge k+N·P, for exactly one cycle.
- Earliest next start acceptance is edge k+N·P+1.
- Zero-step command: done is high after edge k.
- P=1 gives one step per clock.
- Stop sampled at edge s: busy is low after s. The last step is the one whose tick occurred before s.

## Test plan
- **Reset:** assert rst_n=0 mid-move → coil=0000, busy=0, done=0, position=0 immediately, without waiting for clk.
- **Half-step CW:** mode=2, dir=0, steps=3, period=2 from phase 0 → coil 1100 at k+2, 0100 at k+4, 0110 at k+6. done pulses at k+6 and position=3.
- **Wave CCW wrap:** mode=0, dir=1, steps=2, period=0 from phase 1 → aligned to 1000 at k, then 0001, then 0010 on consecutive edges. position=−4.
- **Full-step and zero-steps:** mode=1, steps=0 → single done pulse, busy never high, coil/position unchanged. Then mode=1, steps=4 from phase 0 → aligned 1100 at k, then 0110, 0011, 1001, 1100 (wraps index 7→1).
- **Stop and hold:** steps=10, period=3; assert stop coincident with the 2nd tick → exactly 1 step taken, no done. With hold_en=1 coil holds table[phase]; with hold_en=0 coil=0000.
- **Position wrap and busy start:** POS_W=4, position 6, half-step CW steps=3 → position wraps to −7. A start pulse during RUN is ignored (remaining unchanged).
